// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor. One 4-bit slice is reused for every
// nibble, least-significant first. A registered carry links the nibbles.
// The result, cout and ovf are published together when the last nibble completes.
module nibble_serial_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sub_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   work_r;

    logic               accept;
    logic               last;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [4:0]         slice_sum;
    logic [WIDTH-1:0]   work_next;
    logic               ovf_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, busy and start acceptance
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shared 4-bit slice: select the current nibble, add, and merge into the work word
    always_comb begin
        nib_a     = '0;
        nib_b     = '0;
        work_next = work_r;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                nib_a = a_r[i*4 +: 4];
                nib_b = b_r[i*4 +: 4];
            end
        end
        slice_sum = {1'b0, nib_a} + {1'b0, nib_b ^ {4{sub_r}}} + {4'b0000, carry_r};
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                work_next[i*4 +: 4] = slice_sum[3:0];
            end
        end
        last     = (idx_r == IDX_W'(NIBBLES - 1));
        // Signed overflow: operands of equal sign (after inverting b for subtract) and a result of the other sign
        ovf_next = (a_r[WIDTH-1] == (b_r[WIDTH-1] ^ sub_r)) &&
                   (work_next[WIDTH-1] != a_r[WIDTH-1]);
    end

    // Operand capture, per-nibble progress and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            work_r  <= '0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_r     <= a;
                b_r     <= b;
                sub_r   <= sub;
                carry_r <= sub;
                idx_r   <= '0;
            end else if (state == RUN) begin
                work_r  <= work_next;
                carry_r <= slice_sum[4];
                idx_r   <= idx_r + IDX_W'(1);
                if (last) begin
                    s    <= work_next;
                    cout <= slice_sum[4];
                    ovf  <= ovf_next;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
